alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Execute-side pipeline stage that sits directly upstream of the ALU. It holds the register file, selects operands (register, immediate, or bypassed ALU result), and presents registered `DatA`/`DatB`/`ALUop` to the ALU. On the following edge it retires the ALU's `Rslt`/`Zero`/`Par`/`SCo` into the destination register and the flag register. A `Hold` input from downstream freezes the stage and back-pressures the decoder through a valid/ready handshake.

## Interface
- `NREG`, 8: number of general registers; index width is $clog2(NREG).
- `W`, 8: datapath width.
- `CW`, 8: retire-counter width.

- `Clk` in 1: clock; all state updates on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `InValid` in 1: decoder presents an instruction.
- `InReady` out 1: stage accepts the instruction this cycle; equals `!Hold`.
- `Op` in 3: ALU opcode, passed through unchanged (0 AND, 1 ADD, 2 SUB, 3 OR, 4 LSH, 5 RSH, 6 CMP).
- `RdA` in log2(NREG): source-A register and destination register.
- `RdB` in log2(NREG): source-B register.
- `UseImm` in 1: B operand is `Imm` instead of regs[RdB].
- `Imm` in W: immediate operand.
- `WrEn` in 1: write the result to regs[RdA] at retire.
- `Hold` in 1: downstream stall; freezes all state.
- `DatA`, `DatB` out W: registered operands to the ALU.
- `ALUop` out 3: registered opcode to the ALU.
- `OutValid` out 1: the E register holds a live instruction.
- `Rslt` in W, `Zero` in 1, `Par` in 1, `SCo` in 1: combinational ALU results for the current E-register contents.
- `Flags` out 3: {C, P, Z}, captured from {SCo, Par, Zero}.
- `RetireCnt` out CW: count of retired instructions.
- `DbgAddr` in log2(NREG), `DbgDat` out W: combinational read of regs[DbgAddr], with no bypass.

## Operation
- **State**
  - regs[0..NREG-1].
  - E register: EValid, EOp, EA, EB, EDst, EWr.
  - Flags.
  - RetireCnt.
- **Outputs from state:** DatA=EA, DatB=EB, ALUop=EOp, OutValid=EValid.
- **Operand select (combinational, for the incoming instruction)**
  - A = (EValid & EWr & EDst==RdA) ? Rslt : regs[RdA].
  - B = UseImm ? Imm : ((EValid & EWr & EDst==RdB) ? Rslt : regs[RdB]).
  - Register 0 is an ordinary register; it is not hardwired to zero.
- **Edge with Hold=0**
  - If EValid (retire):
    - When EWr=1, regs[EDst] <= Rslt.
    - Flags <= {SCo, Par, Zero}, regardless of EWr.
    - RetireCnt <= RetireCnt+1, wrapping modulo 2^CW.
  - Load E:
    - EValid <= InValid.
    - When InValid=1, also EA<=A, EB<=B, EOp<=Op, EDst<=RdA, EWr<=WrEn.
    - When InValid=0, the E payload holds its old value and only EValid clears.
- **Edge with Hold=1:** nothing changes, including regs, Flags, RetireCnt and E. InReady=0, so no instruction is accepted.
- The decoder keeps `InValid` and its payload stable until `InValid & InReady`.
- CMP (op 6) retires like any other op; its Rslt[1:0] encoding is written only when WrEn=1.
- Reset (async, Reset_n=0) clears all regs, the E register, Flags and RetireCnt to 0.
  - An in-flight instruction is discarded and never written back.
- `DbgDat` reflects register contents after writeback edges only.

## Timing
- Reset values: DatA=0, DatB=0, ALUop=0, OutValid=0, Flags=0, RetireCnt=0, DbgDat=0. InReady follows Hold.
- Latency:
  - Accepted at edge N: operands are on `DatA`/`DatB` after edge N.
  - Writeback and flags are visible after edge N+1 (Hold=0 assumed).
- Throughput is one instruction per cycle while Hold=0.
  - Back-to-back dependent instructions need no stall; the bypass supplies Rslt in the same cycle.
- Retire and load happen on the same edge. A retiring write and an incoming read of the same register resolve through the bypass, never through a stale regs value.
- Hold asserted at any cycle freezes DatA/DatB/ALUop, so the ALU output stays stable for the whole hold.
- RetireCnt wraps from 2^CW-1 to 0 with no flag.

## Test plan
- **Reset:** pulse Reset_n low mid-stream with OutValid=1.
  - Immediately: DatA=DatB=0, ALUop=0, OutValid=0, Flags=0, RetireCnt=0.
  - DbgDat=0 for every address.
  - The discarded instruction never writes.
- **Immediate load and bypass:** OR r1,#3 (WrEn) then ADD r1,#4 back-to-back.
  - Second cycle: DatA=3, DatB=4, ALUop=1.
  - After retire: DbgDat(r1)=7, RetireCnt=2.
- **Hold:** with ADD r2,#9 in E, hold Hold=1 for 3 cycles while InValid=1.
  - InReady=0; DatA/DatB/ALUop unchanged; RetireCnt and r2 unchanged.
  - On release, retire occurs one edge later.
- **Flags:** load r3=5, then SUB r3,#5.
  - Flags={SCo,Par,1}, with SCo/Par matching the ALU; r3=0.
  - Then AND with WrEn=0: r3 unchanged, Flags updated.
- **Bubble:** InValid=0 for one cycle between two instructions.
  - OutValid drops for exactly that cycle; no extra retire.
  - RetireCnt advances by 2 total.
- **Counter wrap (CW=8):** issue 256 retiring NOPs (OR r0,#0).
  - RetireCnt returns to 0; r0 stays 0.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// Decoder-to-stage handshake and stage-to-ALU operand/result bus.
// The stage is the slave; the decoder/ALU side is the master.
interface alu_operand_stage_if #(
    parameter int NREG = 8,
    parameter int W    = 8
);
    localparam int AW = $clog2(NREG);

    logic          InValid;
    logic          InReady;
    logic [2:0]    Op;
    logic [AW-1:0] RdA;
    logic [AW-1:0] RdB;
    logic          UseImm;
    logic [W-1:0]  Imm;
    logic          WrEn;

    logic [W-1:0]  DatA;
    logic [W-1:0]  DatB;
    logic [2:0]    ALUop;
    logic          OutValid;
    logic [W-1:0]  Rslt;
    logic          Zero;
    logic          Par;
    logic          SCo;

    modport master (
        output InValid, Op, RdA, RdB, UseImm, Imm, WrEn, Rslt, Zero, Par, SCo,
        input  InReady, DatA, DatB, ALUop, OutValid
    );

    modport slave (
        input  InValid, Op, RdA, RdB, UseImm, Imm, WrEn, Rslt, Zero, Par, SCo,
        output InReady, DatA, DatB, ALUop, OutValid
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Execute-side operand stage: register file, operand select with ALU-result bypass,
// registered operands to the ALU, and retire of the ALU result into regs/flags.
module alu_operand_stage #(
    parameter int NREG = 8,
    parameter int W    = 8,
    parameter int CW   = 8
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    alu_operand_stage_if.slave       bus,
    input  logic                     Hold,
    output logic [2:0]               Flags,
    output logic [CW-1:0]            RetireCnt,
    input  logic [$clog2(NREG)-1:0]  DbgAddr,
    output logic [W-1:0]             DbgDat
);
    localparam int AW = $clog2(NREG);

    logic [W-1:0]  regs_q [NREG];
    logic [W-1:0]  regs_d [NREG];
    logic          e_vld_q, e_vld_d;
    logic [2:0]    e_op_q, e_op_d;
    logic [W-1:0]  e_a_q, e_a_d;
    logic [W-1:0]  e_b_q, e_b_d;
    logic [AW-1:0] e_dst_q, e_dst_d;
    logic          e_wr_q, e_wr_d;
    logic [2:0]    flags_q, flags_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          byp_a, byp_b;
    logic [W-1:0]  opa, opb;
    logic          advance, retire;

    always_comb begin
        // A result still sitting in E is newer than the register file copy.
        byp_a   = e_vld_q && e_wr_q && (e_dst_q == bus.RdA);
        byp_b   = e_vld_q && e_wr_q && (e_dst_q == bus.RdB);
        opa     = byp_a ? bus.Rslt : regs_q[bus.RdA];
        opb     = bus.UseImm ? bus.Imm : (byp_b ? bus.Rslt : regs_q[bus.RdB]);
        advance = !Hold;
        retire  = advance && e_vld_q;

        regs_d  = regs_q;
        e_vld_d = e_vld_q;
        e_op_d  = e_op_q;
        e_a_d   = e_a_q;
        e_b_d   = e_b_q;
        e_dst_d = e_dst_q;
        e_wr_d  = e_wr_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;

        if (retire) begin
            if (e_wr_q) begin
                regs_d[e_dst_q] = bus.Rslt;
            end
            flags_d = {bus.SCo, bus.Par, bus.Zero};
            cnt_d   = cnt_q + CW'(1);
        end

        if (advance) begin
            e_vld_d = bus.InValid;
            if (bus.InValid) begin
                e_a_d   = opa;
                e_b_d   = opb;
                e_op_d  = bus.Op;
                e_dst_d = bus.RdA;
                e_wr_d  = bus.WrEn;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            regs_q  <= '{default: '0};
            e_vld_q <= 1'b0;
            e_op_q  <= '0;
            e_a_q   <= '0;
            e_b_q   <= '0;
            e_dst_q <= '0;
            e_wr_q  <= 1'b0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            e_vld_q <= e_vld_d;
            e_op_q  <= e_op_d;
            e_a_q   <= e_a_d;
            e_b_q   <= e_b_d;
            e_dst_q <= e_dst_d;
            e_wr_q  <= e_wr_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.InReady  = !Hold;
    assign bus.DatA     = e_a_q;
    assign bus.DatB     = e_b_q;
    assign bus.ALUop    = e_op_q;
    assign bus.OutValid = e_vld_q;
    assign Flags        = flags_q;
    assign RetireCnt    = cnt_q;
    assign DbgDat       = regs_q[DbgAddr];
endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage with a behavioural ALU closing the bypass loop.
module tb_alu_operand_stage;
    localparam int NREG = 8;
    localparam int W    = 8;
    localparam int CW   = 8;

    logic          Clk;
    logic          Reset_n;
    logic          Hold;
    logic [2:0]    Flags;
    logic [CW-1:0] RetireCnt;
    logic [2:0]    DbgAddr;
    logic [W-1:0]  DbgDat;

    alu_operand_stage_if #(.NREG(NREG), .W(W)) bus ();

    alu_operand_stage #(.NREG(NREG), .W(W), .CW(CW)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .bus       (bus),
        .Hold      (Hold),
        .Flags     (Flags),
        .RetireCnt (RetireCnt),
        .DbgAddr   (DbgAddr),
        .DbgDat    (DbgDat)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural ALU: SUB carry is the carry-out of a + ~b + 1 (1 = no borrow).
    logic [W:0]   alu_t;
    logic [W-1:0] alu_r;
    logic         alu_c;
    always_comb begin
        alu_t = '0;
        alu_r = '0;
        alu_c = 1'b0;
        case (bus.ALUop)
            3'd0: alu_r = bus.DatA & bus.DatB;
            3'd1: begin alu_t = {1'b0, bus.DatA} + {1'b0, bus.DatB}; alu_r = alu_t[W-1:0]; alu_c = alu_t[W]; end
            3'd2: begin alu_t = {1'b0, bus.DatA} + {1'b0, ~bus.DatB} + (W+1)'(1); alu_r = alu_t[W-1:0]; alu_c = alu_t[W]; end
            3'd3: alu_r = bus.DatA | bus.DatB;
            3'd4: alu_r = bus.DatA << bus.DatB[2:0];
            3'd5: alu_r = bus.DatA >> bus.DatB[2:0];
            3'd6: alu_r = {6'b0, (bus.DatA < bus.DatB), (bus.DatA == bus.DatB)};
            default: alu_r = '0;
        endcase
        bus.Rslt = alu_r;
        bus.SCo  = alu_c;
        bus.Par  = ^alu_r;
        bus.Zero = (alu_r == '0);
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: each presented operand set must match the oldest expected entry;
    // the entry is consumed on the cycle the stage is allowed to retire it.
    always @(negedge Clk) begin
        if (Reset_n && bus.OutValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got op %0d a %0h b %0h expected none", bus.ALUop, bus.DatA, bus.DatB);
            end else begin
                chk("sb_DatA", 32'(bus.DatA), 32'(exp_q[0].a));
                chk("sb_DatB", 32'(bus.DatB), 32'(exp_q[0].b));
                chk("sb_ALUop", 32'(bus.ALUop), 32'(exp_q[0].op));
                if (!Hold) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] rda, input logic [2:0] rdb,
                         input logic useimm, input logic [W-1:0] imm, input logic wr,
                         input logic [W-1:0] ea, input logic [W-1:0] eb);
        exp_t e;
        bus.InValid = 1'b1;
        bus.Op      = op;
        bus.RdA     = rda;
        bus.RdB     = rdb;
        bus.UseImm  = useimm;
        bus.Imm     = imm;
        bus.WrEn    = wr;
        e.a = ea; e.b = eb; e.op = op;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        bus.InValid = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [2:0] addr, input logic [W-1:0] req);
        DbgAddr = addr;
        #1;
        chk(name, 32'(DbgDat), 32'(req));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_DatA"}, 32'(bus.DatA), 32'h0);
        chk({tag, "_DatB"}, 32'(bus.DatB), 32'h0);
        chk({tag, "_ALUop"}, 32'(bus.ALUop), 32'h0);
        chk({tag, "_OutValid"}, 32'(bus.OutValid), 32'h0);
        chk({tag, "_Flags"}, 32'(Flags), 32'h0);
        chk({tag, "_RetireCnt"}, 32'(RetireCnt), 32'h0);
        for (int i = 0; i < NREG; i++) chk_reg({tag, "_DbgDat"}, 3'(i), 8'h00);
    endtask

    initial begin
        Reset_n = 1'b1;
        Hold = 1'b0;
        DbgAddr = '0;
        bus.InValid = 1'b0;
        bus.Op = '0;
        bus.RdA = '0;
        bus.RdB = '0;
        bus.UseImm = 1'b0;
        bus.Imm = '0;
        bus.WrEn = 1'b0;
        #1 Reset_n = 1'b0;
        #1;
        chk_reset_state("rst0");
        chk("rst0_InReady", 32'(bus.InReady), 32'h1);
        Hold = 1'b1;
        #1 chk("rst0_InReady_hold", 32'(bus.InReady), 32'h0);
        Hold = 1'b0;
        step();
        Reset_n = 1'b1;
        step();

        // Immediate load followed by dependent ADD through the bypass.
        drive(3'd3, 3'd1, 3'd0, 1'b1, 8'd3, 1'b1, 8'd0, 8'd3); step();
        drive(3'd1, 3'd1, 3'd0, 1'b1, 8'd4, 1'b1, 8'd3, 8'd4); step();
        idle(); step();
        chk_reg("bypass_r1", 3'd1, 8'd7);
        chk("bypass_cnt", 32'(RetireCnt), 32'd2);
        chk("bypass_flags", 32'(Flags), 32'b010);

        // Hold for three cycles with the next instruction waiting.
        drive(3'd1, 3'd2, 3'd0, 1'b1, 8'd9, 1'b1, 8'd0, 8'd9); step();
        Hold = 1'b1;
        drive(3'd3, 3'd4, 3'd0, 1'b1, 8'd5, 1'b1, 8'd0, 8'd5);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_InReady", 32'(bus.InReady), 32'h0);
            chk("hold_OutValid", 32'(bus.OutValid), 32'h1);
            step();
            chk("hold_cnt", 32'(RetireCnt), 32'd2);
            chk_reg("hold_r2", 3'd2, 8'd0);
        end
        Hold = 1'b0;
        step();
        chk_reg("release_r2", 3'd2, 8'd9);
        chk("release_cnt", 32'(RetireCnt), 32'd3);
        idle(); step();
        chk_reg("release_r4", 3'd4, 8'd5);
        chk("release_cnt2", 32'(RetireCnt), 32'd4);

        // Flags from SUB to zero, then a non-writing AND.
        drive(3'd3, 3'd3, 3'd0, 1'b1, 8'd5, 1'b1, 8'd0, 8'd5); step();
        drive(3'd2, 3'd3, 3'd0, 1'b1, 8'd5, 1'b1, 8'd5, 8'd5); step();
        drive(3'd0, 3'd1, 3'd0, 1'b1, 8'd6, 1'b0, 8'd7, 8'd6); step();
        chk("sub_flags", 32'(Flags), 32'b101);
        chk_reg("sub_r3", 3'd3, 8'd0);
        idle(); step();
        chk("and_flags", 32'(Flags), 32'b000);
        chk_reg("and_r1", 3'd1, 8'd7);
        chk_reg("and_r3", 3'd3, 8'd0);
        chk("and_cnt", 32'(RetireCnt), 32'd7);

        // One-cycle bubble between two instructions.
        drive(3'd3, 3'd5, 3'd0, 1'b1, 8'd1, 1'b1, 8'd0, 8'd1); step();
        idle(); step();
        chk("bubble_OutValid", 32'(bus.OutValid), 32'h0);
        chk("bubble_cnt", 32'(RetireCnt), 32'd8);
        drive(3'd3, 3'd5, 3'd0, 1'b1, 8'd2, 1'b1, 8'd1, 8'd2); step();
        chk("bubble_OutValid2", 32'(bus.OutValid), 32'h1);
        chk("bubble_cnt2", 32'(RetireCnt), 32'd8);
        idle(); step();
        chk("bubble_cnt3", 32'(RetireCnt), 32'd9);
        chk_reg("bubble_r5", 3'd5, 8'd3);

        // Reset mid-stream with a live instruction in E.
        drive(3'd3, 3'd6, 3'd0, 1'b1, 8'd7, 1'b1, 8'd0, 8'd7); step();
        idle();
        chk("pre_rst_OutValid", 32'(bus.OutValid), 32'h1);
        Reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_state("rst1");
        step();
        Reset_n = 1'b1;
        step();
        chk_reg("rst1_r6_after", 3'd6, 8'd0);
        chk("rst1_cnt_after", 32'(RetireCnt), 32'd0);

        // 256 retiring NOPs wrap the counter back to zero.
        for (int i = 0; i < 256; i++) begin
            drive(3'd3, 3'd0, 3'd0, 1'b1, 8'd0, 1'b1, 8'd0, 8'd0);
            step();
        end
        chk("wrap_cnt_255", 32'(RetireCnt), 32'd255);
        idle(); step();
        chk("wrap_cnt_0", 32'(RetireCnt), 32'd0);
        chk_reg("wrap_r0", 3'd0, 8'd0);

        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
